// File: rtl/mem_access_pkg.sv
// Shared definitions for the data-memory access unit: size encodings,
// the FSM state type, and the sub-word merge / load-extract helpers.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        IDLE  = 1'b0,
        MERGE = 1'b1
    } state_t;

    // Replace the addressed byte/half of old_word with the low bits of wdata.
    // Word (and the reserved encoding) replaces the whole word.
    function automatic logic [31:0] lane_merge(
        input logic [31:0] old_word,
        input logic [31:0] wdata,
        input logic [1:0]  size,
        input logic [1:0]  boff
    );
        logic [31:0] w;
        w = old_word;
        if (size == SZ_BYTE) begin
            case (boff)
                2'd0:    w[7:0]   = wdata[7:0];
                2'd1:    w[15:8]  = wdata[7:0];
                2'd2:    w[23:16] = wdata[7:0];
                default: w[31:24] = wdata[7:0];
            endcase
        end else if (size == SZ_HALF) begin
            if (boff[1]) w[31:16] = wdata[15:0];
            else         w[15:0]  = wdata[15:0];
        end else begin
            w = wdata;
        end
        return w;
    endfunction

    // Pick the addressed lane out of a RAM word and sign/zero extend it.
    function automatic logic [31:0] load_extract(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic        uns,
        input logic [1:0]  boff
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (boff)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = boff[1] ? word[31:16] : word[15:0];
        if (size == SZ_BYTE)      r = uns ? {24'b0, b} : {{24{b[7]}}, b};
        else if (size == SZ_HALF) r = uns ? {16'b0, h} : {{16{h[15]}}, h};
        else                      r = word;
        return r;
    endfunction

endpackage

// File: rtl/mau_lane_extract.sv
// Combinational load-lane selection with sign/zero extension.
module mau_lane_extract
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [1:0]  boff,
    output logic [31:0] data
);

    // Lane select and extend in one step; no state.
    always_comb begin
        data = load_extract(word, size, uns, boff);
    end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory front end: byte address -> word index, zero-latency loads with
// lane extraction, single-cycle SW, two-cycle read-modify-write SH/SB.
// Misaligned requests are flagged, never written, and latch err_sticky.
//
// Handshake: there is no valid/ready pair; req is a one-cycle request that is
// always consumed in IDLE. stall=1 tells the pipeline to hold its MEM stage one
// extra cycle while a sub-word store completes in MERGE; anything presented on
// req/wr/addr during MERGE is ignored.
//
// Build option: define MEM_ACCESS_STATS_EN to add saturating ld_cnt/st_cnt.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int RAM_AW = 10,
    parameter int DW     = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          wr,
    input  logic [1:0]    size,
    input  logic          uns,
    input  logic [31:0]   addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          stall,
    output logic          misalign,
    output logic          err_sticky,
    output logic [31:0]   ram_a,
    output logic [DW-1:0] ram_wd,
    output logic          ram_we,
    input  logic [DW-1:0] ram_rd,
    output state_t        dbg_state
`ifdef MEM_ACCESS_STATS_EN
    ,
    output logic [15:0]   ld_cnt,
    output logic [15:0]   st_cnt
`endif
);

    state_t              state_q, state_d;
    logic [RAM_AW-1:0]   idx_q;
    logic [31:0]         merge_q;
    logic [RAM_AW-1:0]   addr_idx;
    logic [RAM_AW-1:0]   ram_idx;
    logic [31:0]         ext_data;
    logic                load_ok;
    logic                capture;
    logic                unused_addr_hi;

    // Upper address bits fall off the word index, so indices wrap.
    assign addr_idx       = addr[RAM_AW+1:2];
    assign unused_addr_hi = ^addr[31:RAM_AW+2];

    assign misalign = req & (((size == SZ_HALF) & addr[0]) |
                             (size[1] & (addr[1:0] != 2'b00)));

    assign ram_a     = {{(32-RAM_AW){1'b0}}, ram_idx};
    assign dbg_state = state_q;

    mau_lane_extract u_extract (
        .word (ram_rd),
        .size (size),
        .uns  (uns),
        .boff (addr[1:0]),
        .data (ext_data)
    );

    // Next state and all RAM/pipeline controls; writes and stall are gated
    // off while reset is low so nothing reaches the RAM during its clear.
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        ram_we  = 1'b0;
        ram_idx = addr_idx;
        ram_wd  = wdata;
        load_ok = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (req && !misalign) begin
                    if (!wr) begin
                        load_ok = 1'b1;
                    end else if (size[1]) begin
                        ram_we = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        capture = 1'b1;
                        state_d = MERGE;
                    end
                end
            end
            MERGE: begin
                ram_idx = idx_q;
                ram_wd  = merge_q;
                ram_we  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (!reset) begin
            stall  = 1'b0;
            ram_we = 1'b0;
        end
    end

    assign rdata = load_ok ? ext_data : '0;

    // State, held RMW index/word, and the sticky misalignment flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            merge_q    <= '0;
            err_sticky <= 1'b0;
        end else begin
            state_q    <= state_d;
            err_sticky <= err_sticky | misalign;
            if (capture) begin
                idx_q   <= addr_idx;
                merge_q <= lane_merge(ram_rd, wdata, size, addr[1:0]);
            end
        end
    end

`ifdef MEM_ACCESS_STATS_EN
    logic st_evt;
    assign st_evt = ram_we;

    // Saturating counters of accepted aligned loads and completed stores.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ld_cnt <= '0;
            st_cnt <= '0;
        end else begin
            if (load_ok && (ld_cnt != 16'hFFFF)) ld_cnt <= ld_cnt + 16'd1;
            if (st_evt  && (st_cnt != 16'hFFFF)) st_cnt <= st_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a behavioural word RAM.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic        clk;
    logic        reset;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        misalign;
    logic        err_sticky;
    logic [31:0] ram_a;
    logic [31:0] ram_wd;
    logic        ram_we;
    logic [31:0] ram_rd;
    state_t      dbg_state;
`ifdef MEM_ACCESS_STATS_EN
    logic [15:0] ld_cnt;
    logic [15:0] st_cnt;
`endif

    mem_access_unit #(.RAM_AW(10), .DW(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .wr         (wr),
        .size       (size),
        .uns        (uns),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .stall      (stall),
        .misalign   (misalign),
        .err_sticky (err_sticky),
        .ram_a      (ram_a),
        .ram_wd     (ram_wd),
        .ram_we     (ram_we),
        .ram_rd     (ram_rd),
        .dbg_state  (dbg_state)
`ifdef MEM_ACCESS_STATS_EN
        ,
        .ld_cnt     (ld_cnt),
        .st_cnt     (st_cnt)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- RAM model ----------------
    logic [31:0] mem [1024];
    assign ram_rd = mem[ram_a[9:0]];
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
        end else if (ram_we) begin
            mem[ram_a[9:0]] <= ram_wd;
        end
    end

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    logic [63:0] wexp_q[$];
    logic [31:0] shadow [1024];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Every RAM write seen is compared against the queued expected write.
    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            if (wexp_q.size() == 0) check("unexpected_write", {ram_a, ram_wd}, 64'h0);
            else check("ram_write", {ram_a, ram_wd}, wexp_q.pop_front());
        end
    end

    // Independent reference: shifts and masks over the shadow copy.
    function automatic logic [31:0] ld_model(input logic [31:0] w, input logic [1:0] sz,
                                             input logic u, input logic [1:0] a);
        logic [31:0] s;
        if (sz == SZ_BYTE) begin
            s = w >> (8 * a);
            return u ? (s & 32'hFF) : {{24{s[7]}}, s[7:0]};
        end else if (sz == SZ_HALF) begin
            s = w >> (16 * a[1]);
            return u ? (s & 32'hFFFF) : {{16{s[15]}}, s[15:0]};
        end
        return w;
    endfunction

    function automatic logic [31:0] st_model(input logic [31:0] old, input logic [31:0] d,
                                             input logic [1:0] sz, input logic [1:0] a);
        logic [31:0] m;
        if (sz == SZ_BYTE) begin
            m = 32'hFF << (8 * a);
            return (old & ~m) | ((d & 32'hFF) << (8 * a));
        end else if (sz == SZ_HALF) begin
            m = 32'hFFFF << (16 * a[1]);
            return (old & ~m) | ((d & 32'hFFFF) << (16 * a[1]));
        end
        return d;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic r, input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        req = r; wr = w; size = sz; uns = u; addr = a; wdata = d;
    endtask

    task automatic idle_cycle();
        drive(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("idle_rdata", rdata, 32'h0);
    endtask

    task automatic clear_shadow();
        for (int i = 0; i < 1024; i++) shadow[i] = 32'h0;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic u,
                           input logic [31:0] exp);
        drive(1'b1, 1'b0, sz, u, a, 32'h0);
        exp_q.push_back(exp);
        @(negedge clk);
        check("ld_rdata", rdata, exp_q.pop_front());
        check("ld_stall", stall, 1'b0);
    endtask

    task automatic do_sw(input logic [31:0] a, input logic [31:0] d);
        wexp_q.push_back({22'h0, a[11:2], d});
        shadow[a[11:2]] = d;
        drive(1'b1, 1'b1, SZ_WORD, 1'b0, a, d);
        @(negedge clk);
        check("sw_stall", stall, 1'b0);
    endtask

    // Sub-word store; a conflicting SW is presented during MERGE to show it is ignored.
    task automatic do_sub(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] nw;
        nw = st_model(shadow[a[11:2]], d, sz, a[1:0]);
        shadow[a[11:2]] = nw;
        wexp_q.push_back({22'h0, a[11:2], nw});
        drive(1'b1, 1'b1, sz, 1'b0, a, d);
        @(negedge clk);
        check("sub_stall", stall, 1'b1);
        drive(1'b1, 1'b1, SZ_WORD, 1'b0, 32'h3FC, 32'hFFFF_FFFF);
        @(negedge clk);
        check("merge_stall", stall, 1'b0);
        check("merge_state", dbg_state, MERGE);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t0;
        int t1;
        reset = 1'b0; req = 1'b0; wr = 1'b0; size = SZ_WORD; uns = 1'b0;
        addr = 32'h0; wdata = 32'h0;
        clear_shadow();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_we", ram_we, 1'b0);
        check("rst_stall", stall, 1'b0);
        check("rst_err", err_sticky, 1'b0);
        check("rst_state", dbg_state, IDLE);
        reset = 1'b1;

        // Loads from a known word
        do_sw(32'h4, 32'h8899_AABB);
        do_load(32'h4, SZ_BYTE, 1'b0, 32'hFFFF_FFBB);
        do_load(32'h6, SZ_BYTE, 1'b1, 32'h0000_0099);
        do_load(32'h6, SZ_HALF, 1'b0, 32'hFFFF_8899);
        do_load(32'h4, SZ_HALF, 1'b1, 32'h0000_AABB);
        do_load(32'h7, SZ_BYTE, 1'b0, 32'hFFFF_FF88);
        do_load(32'h4, SZ_WORD, 1'b0, 32'h8899_AABB);

        // Misaligned word load and half store
        drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h5, 32'h0);
        @(negedge clk);
        check("mis_flag", misalign, 1'b1);
        check("mis_rdata", rdata, 32'h0);
        check("mis_stall", stall, 1'b0);
        check("mis_err_before", err_sticky, 1'b0);
        drive(1'b1, 1'b1, SZ_HALF, 1'b0, 32'h3, 32'hFFFF);
        @(negedge clk);
        check("mis_err_after", err_sticky, 1'b1);
        check("mis_sh_flag", misalign, 1'b1);
        check("mis_sh_stall", stall, 1'b0);
        idle_cycle();
        do_load(32'h0, SZ_WORD, 1'b0, 32'h0);

        // SB into a zero word, then read back
        do_sub(32'h9, SZ_BYTE, 32'h12);
        do_load(32'h8, SZ_WORD, 1'b0, 32'h0000_1200);

        // Back-to-back SW then SH
        do_sw(32'h0, 32'hDEAD_BEEF);
        t0 = cyc;
        do_sub(32'h2, SZ_HALF, 32'h5A5A);
        t1 = cyc;
        check("b2b_cycles", t1 - t0 + 1, 3);
        do_load(32'h0, SZ_WORD, 1'b0, 32'h5A5A_BEEF);

        // Index wrap: 0x1010 aliases word 4
        do_sw(32'h1010, 32'hCAFE_0001);
        do_load(32'h10, SZ_WORD, 1'b0, 32'hCAFE_0001);

        // Random mix over words 16..23
        for (int it = 0; it < 40; it++) begin
            int k;
            logic [31:0] a;
            logic [31:0] d;
            logic        u;
            k = $urandom_range(0, 4);
            a = 32'((16 + $urandom_range(0, 7)) * 4);
            d = $urandom;
            u = 1'($urandom_range(0, 1));
            case (k)
                0: do_sw(a, d);
                1: do_sub(a + 32'(2 * $urandom_range(0, 1)), SZ_HALF, d);
                2: do_sub(a + 32'($urandom_range(0, 3)), SZ_BYTE, d);
                3: begin
                    a = a + 32'($urandom_range(0, 3));
                    do_load(a, SZ_BYTE, u, ld_model(shadow[a[11:2]], SZ_BYTE, u, a[1:0]));
                end
                default: begin
                    a = a + 32'(2 * $urandom_range(0, 1));
                    do_load(a, SZ_HALF, u, ld_model(shadow[a[11:2]], SZ_HALF, u, a[1:0]));
                    do_load(a & ~32'h3, SZ_WORD, 1'b0, shadow[a[11:2]]);
                end
            endcase
        end

        // Reset during MERGE of an SB: write dropped, state and sticky cleared
        check("pre_rst_err", err_sticky, 1'b1);
        drive(1'b1, 1'b1, SZ_BYTE, 1'b0, 32'h15, 32'h77);
        @(negedge clk);
        check("rstm_stall", stall, 1'b1);
        @(posedge clk);
        #1;
        check("rstm_in_merge", dbg_state, MERGE);
        #1;
        reset = 1'b0;
        #1;
        check("rstm_we", ram_we, 1'b0);
        check("rstm_stall0", stall, 1'b0);
        check("rstm_state", dbg_state, IDLE);
        check("rstm_err", err_sticky, 1'b0);
        req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        clear_shadow();
        do_load(32'h14, SZ_WORD, 1'b0, 32'h0);
        do_load(32'h4, SZ_WORD, 1'b0, 32'h0);

`ifdef MEM_ACCESS_STATS_EN
        // Three loads (two above) plus stores; counters started at reset
        do_load(32'h8, SZ_BYTE, 1'b0, 32'h0);
        do_sw(32'h20, 32'h1234_5678);
        do_sub(32'h25, SZ_BYTE, 32'hAB);
        idle_cycle();
        check("ld_cnt", ld_cnt, 16'd3);
        check("st_cnt", st_cnt, 16'd2);
        drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
        repeat (65540) @(posedge clk);
        @(negedge clk);
        check("ld_sat", ld_cnt, 16'hFFFF);
        do_load(32'h20, SZ_WORD, 1'b0, 32'h1234_5678);
        idle_cycle();
        check("ld_sat_hold", ld_cnt, 16'hFFFF);
        check("st_cnt_after", st_cnt, 16'd2);
`endif

        idle_cycle();
        check("wexp_drained", 64'(wexp_q.size()), 64'h0);
        check("exp_drained", 64'(exp_q.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
